aes_128_key_round_gen: RTL and testbench

- On-the-fly AES-128 key schedule. Sits directly upstream of the AES-128 round controller and round datapath.
- Captures the 128-bit cipher key when a block is accepted, then produces one round key per advance, K0 to K10.
- Raises the round-10-completed indication that the controller consumes to end a block.

---
 rtl/aes_128_pkg.sv | 22 ++
 rtl/aes_sub_word.sv | 35 +++
 rtl/aes_128_key_round_gen.sv | 111 +++++++++++
 tb/tb_aes_128_key_round_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_128_pkg.sv
// Shared AES-128 definitions: widths, round-constant table, key-schedule
// state encoding and common block/index types.
package aes_128_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;

  typedef logic [KEY_W-1:0] aes_block_t;
  typedef logic [3:0]       round_idx_t;

  typedef enum logic {
    IDLE,
    RUN
  } key_gen_state_e;

  // Round constants indexed by the round being produced; entry 0 is unused.
  localparam logic [7:0] RCON [NUM_ROUNDS+1] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_sub_word.sv
// AES SubWord: four parallel forward S-box byte substitutions on a 32-bit word.
// Purely combinational so it can be shared with the round datapath.
module aes_sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  // Forward S-box, entry 0 first.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte-wise table lookup; every output byte is written each evaluation.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      word_o[8*i +: 8] = SBOX[word_i[8*i +: 8]];
    end
  end

endmodule

// File: rtl/aes_128_key_round_gen.sv
// On-the-fly AES-128 key schedule. Captures the cipher key on key_load_i and
// steps K0..K10 one round per round_adv_i, flagging completion at K10.
// Optional macro AES_KEY_STORE_EN adds an 11-entry round-key store with a
// combinational read port for reverse-order key delivery.
module aes_128_key_round_gen
  import aes_128_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_load_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic             round_adv_i,
  output logic [KEY_W-1:0] round_key_o,
  output logic [3:0]       round_idx_o,
  output logic             key_valid_o,
  output logic             round_10_completed_o
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]       rk_rd_idx_i,
  output logic [KEY_W-1:0] rk_rd_key_o
`endif
);

  key_gen_state_e state_q;
  aes_block_t     round_key_q;
  round_idx_t     round_idx_q;
  logic           key_valid_q;

  aes_block_t     next_key_d;
  round_idx_t     next_idx;
  logic [31:0]    sub_rot_w3;
  logic           last_round;
  logic           adv_en;

  // One key-expansion step given SubWord(RotWord(w3)) and the round constant.
  function automatic aes_block_t key_step(input aes_block_t k,
                                          input logic [31:0] sub_rot,
                                          input logic [7:0]  rcon);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_rot ^ {rcon, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  aes_sub_word u_sub_word (
    .word_i ({round_key_q[23:0], round_key_q[31:24]}),
    .word_o (sub_rot_w3)
  );

  assign next_idx   = round_idx_q + 4'd1;
  assign next_key_d = key_step(round_key_q, sub_rot_w3, RCON[next_idx]);
  assign last_round = (state_q == RUN) && (round_idx_q == round_idx_t'(NUM_ROUNDS));
  // Load has priority, so an advance in the same cycle is dropped.
  assign adv_en     = (state_q == RUN) && !last_round && round_adv_i && !key_load_i;

  // Schedule state: load restarts at K0, K10 retires to IDLE, advance steps a round.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= '0;
      key_valid_q <= 1'b0;
    end else if (key_load_i) begin
      state_q     <= RUN;
      round_key_q <= key_i;
      round_idx_q <= '0;
      key_valid_q <= 1'b1;
    end else if (last_round) begin
      state_q     <= IDLE;
      key_valid_q <= 1'b0;
    end else if (adv_en) begin
      round_key_q <= next_key_d;
      round_idx_q <= next_idx;
    end
  end

  assign round_key_o          = round_key_q;
  assign round_idx_o          = round_idx_q;
  assign key_valid_o          = key_valid_q;
  assign round_10_completed_o = last_round && !key_load_i;

`ifdef AES_KEY_STORE_EN
  aes_block_t rk_store_q [NUM_ROUNDS+1];

  // Record each round key at its index; contents survive a new key load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: this small array is reset on purpose so unread entries return a
    // known zero; large memories normally stay unreset.
    if (rst_i) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_store_q[i] <= '0;
    end else if (key_load_i) begin
      rk_store_q[0] <= key_i;
    end else if (adv_en) begin
      rk_store_q[next_idx] <= next_key_d;
    end
  end

  assign rk_rd_key_o = (rk_rd_idx_i <= round_idx_t'(NUM_ROUNDS)) ? rk_store_q[rk_rd_idx_i] : '0;
`else
  // Store absent: round keys are only available on round_key_o.
`endif

  a_idx_range: assert property (@(posedge clk_i) disable iff (rst_i)
    round_idx_q <= round_idx_t'(NUM_ROUNDS));

endmodule

// File: tb/tb_aes_128_key_round_gen.sv
// Self-checking bench for aes_128_key_round_gen: FIPS-197 schedules driven
// from a vector table, with a scoreboard of expected registered outputs.
module tb_aes_128_key_round_gen;
  import aes_128_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       key_load_i;
  aes_block_t key_i;
  logic       round_adv_i;
  aes_block_t round_key_o;
  logic [3:0] round_idx_o;
  logic       key_valid_o;
  logic       round_10_completed_o;
`ifdef AES_KEY_STORE_EN
  logic [3:0] rk_rd_idx_i;
  aes_block_t rk_rd_key_o;
`endif

  aes_128_key_round_gen dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .key_load_i           (key_load_i),
    .key_i                (key_i),
    .round_adv_i          (round_adv_i),
    .round_key_o          (round_key_o),
    .round_idx_o          (round_idx_o),
    .key_valid_o          (key_valid_o),
    .round_10_completed_o (round_10_completed_o)
`ifdef AES_KEY_STORE_EN
    ,
    .rk_rd_idx_i          (rk_rd_idx_i),
    .rk_rd_key_o          (rk_rd_key_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [10:0][KEY_W-1:0] rk;
  } key_vec_t;

  typedef struct packed {
    aes_block_t key;
    round_idx_t idx;
    logic       valid;
  } exp_t;

  key_vec_t vecs [2];
  exp_t     exp_q [$];

  int   total = 0;
  int   bad   = 0;

  logic m_run    = 1'b0;
  logic m_loaded = 1'b0;
  int   m_idx    = 0;
  int   m_tbl    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic aes_block_t m_key();
    return m_loaded ? vecs[m_tbl].rk[m_idx] : '0;
  endfunction

  // One clock: drive inputs, check the pulse against the current model state,
  // advance the model, then compare the registered outputs after the edge.
  task automatic cycle(input logic load, input int tbl, input logic adv);
    exp_t e;
    @(negedge clk_i);
    key_load_i  = load;
    if (load) key_i = vecs[tbl].rk[0];
    round_adv_i = adv;
    #1;
    check("pulse", 128'(round_10_completed_o), 128'(m_run && m_idx == 10 && !load));
    if (load) begin
      m_run = 1'b1; m_loaded = 1'b1; m_idx = 0; m_tbl = tbl;
    end else if (m_run) begin
      if (m_idx == 10) m_run = 1'b0;
      else if (adv)    m_idx++;
    end
    e.key = m_key(); e.idx = round_idx_t'(m_idx); e.valid = m_run;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 128'(1), 128'(0));
    end else begin
      e = exp_q.pop_front();
      check("round_key", round_key_o, e.key);
      check("round_idx", 128'(round_idx_o), 128'(e.idx));
      check("key_valid", 128'(key_valid_o), 128'(e.valid));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key"},   round_key_o, '0);
    check({tag, "_idx"},   128'(round_idx_o), 128'(0));
    check({tag, "_valid"}, 128'(key_valid_o), 128'(0));
    check({tag, "_pulse"}, 128'(round_10_completed_o), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[0].rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    vecs[0].rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    vecs[0].rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    vecs[0].rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    vecs[0].rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    vecs[0].rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    vecs[0].rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    vecs[0].rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    vecs[0].rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    vecs[0].rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vecs[1].rk[0]  = 128'h00000000000000000000000000000000;
    vecs[1].rk[1]  = 128'h62636363626363636263636362636363;
    vecs[1].rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    vecs[1].rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
    vecs[1].rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    vecs[1].rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    vecs[1].rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
    vecs[1].rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    vecs[1].rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    vecs[1].rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    vecs[1].rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst_i       = 1'b1;
    key_load_i  = 1'b0;
    round_adv_i = 1'b0;
    key_i       = '0;
`ifdef AES_KEY_STORE_EN
    rk_rd_idx_i = '0;
`endif

    // Reset, then idle with round_adv_i toggling.
    #7;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'(i % 2));

    // Full schedules from the vector table with round_adv_i held high.
    for (int v = 0; v < 2; v++) begin
      cycle(1'b1, v, 1'b1);
      for (int i = 0; i < 12; i++) cycle(1'b0, v, 1'b1);
    end

`ifdef AES_KEY_STORE_EN
    // Store holds the zero-key schedule from the last run; index 11 reads zero.
    for (int i = 0; i < 12; i++) begin
      rk_rd_idx_i = 4'(i);
      #1;
      check("store_read", rk_rd_key_o, (i <= 10) ? vecs[1].rk[i] : '0);
    end
`endif

    // Stall three cycles at index 4; completion slips by the same amount.
    cycle(1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 0, 1'b1);

    // Restart with the zero key at index 6, then run it to K10.
    cycle(1'b1, 0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 1, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1, 1'b1);

    // Load at index 10 beats completion: pulse gated in that cycle.
    cycle(1'b1, 0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 1, 1'b0);
    cycle(1'b0, 1, 1'b1);

    // Asynchronous reset at index 7, asserted between clock edges.
    cycle(1'b1, 0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 0, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    m_run = 1'b0; m_loaded = 1'b0; m_idx = 0;
    key_load_i  = 1'b0;
    round_adv_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'(i % 2));

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
